// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART <-> Wishbone bridges (uart2wb, wb2uart).
// Holds FSM state encodings, command-bit position, write-ack byte values and
// the frame-length helpers used by both bridge directions.
package uart_wb_pkg;

    typedef enum logic [1:0] {
        RX_CMD    = 2'd0,
        RX_FIELDS = 2'd1,
        WB_REQ    = 2'd2,
        TX_RESP   = 2'd3
    } state_t;

    localparam int unsigned WE_BIT         = 0;
    localparam logic [7:0]  WR_ACK_OK      = 8'h01;
    localparam logic [7:0]  WR_ACK_TIMEOUT = 8'h00;

    // Number of request bytes that follow the command byte.
    function automatic logic [3:0] req_fields(input logic we, input int unsigned nbytes);
        return we ? 4'(nbytes + 2) : 4'd1;
    endfunction

    // Number of bytes in the response frame.
    function automatic logic [3:0] resp_bytes(input logic we, input int unsigned nbytes);
        return we ? 4'd1 : 4'(nbytes);
    endfunction

endpackage

// File: rtl/uart2wb_if.sv
// Wishbone bus bundle between the uart2wb bridge (master) and a slave.
interface uart2wb_if #(
    parameter int unsigned addr_width   = 8,
    parameter int unsigned data_width   = 8,
    parameter int unsigned strobe_width = data_width / 8
);
    logic [addr_width-1:0]   wb_adr;
    logic [data_width-1:0]   wb_datwr;
    logic [data_width-1:0]   wb_datrd;
    logic                    wb_we;
    logic [strobe_width-1:0] wb_sel;
    logic                    wb_stb;
    logic                    wb_cyc;
    logic                    wb_ack;

    modport master (
        output wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc,
        input  wb_datrd, wb_ack
    );

    modport slave (
        input  wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc,
        output wb_datrd, wb_ack
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// o_valid pulse at the middle of a valid stop bit.
module uart_rx #(
    parameter int unsigned clk_per_bit = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid
);
    localparam int unsigned     CW   = $clog2(clk_per_bit);
    localparam logic [CW-1:0]   FULL = CW'(clk_per_bit - 1);
    localparam logic [CW-1:0]   HALF = CW'(clk_per_bit / 2 - 1);

    logic          r_s1, r_s2, r_busy, r_valid;
    logic [CW-1:0] r_clk;
    logic [3:0]    r_bits;
    logic [7:0]    r_shift, r_data;

    assign o_data  = r_data;
    assign o_valid = r_valid;

    // Synchronise the line, then walk start/data/stop bits on a bit-period counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_busy  <= 1'b0;
            r_clk   <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_s1    <= i_rx;
            r_s2    <= r_s1;
            r_valid <= 1'b0;
            if (!r_busy) begin
                if (!r_s2) begin
                    r_busy <= 1'b1;
                    r_clk  <= '0;
                    r_bits <= '0;
                end
            end else if (r_bits == 4'd0) begin
                if (r_clk == HALF) begin
                    r_clk <= '0;
                    if (r_s2) r_busy <= 1'b0;   // glitch, not a real start bit
                    else      r_bits <= 4'd1;
                end else begin
                    r_clk <= r_clk + 1'b1;
                end
            end else if (r_clk == FULL) begin
                r_clk <= '0;
                if (r_bits == 4'd9) begin
                    r_busy  <= 1'b0;
                    r_valid <= r_s2;
                    r_data  <= r_shift;
                end else begin
                    r_shift <= {r_s2, r_shift[7:1]};
                    r_bits  <= r_bits + 4'd1;
                end
            end else begin
                r_clk <= r_clk + 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. o_done pulses for one cycle after the stop bit while
// the transmitter is already idle, so a new i_load is accepted in that cycle.
module uart_tx #(
    parameter int unsigned clk_per_bit = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_load,
    output logic       o_tx,
    output logic       o_done
);
    localparam int unsigned   CW   = $clog2(clk_per_bit);
    localparam logic [CW-1:0] FULL = CW'(clk_per_bit - 1);

    logic          r_tx, r_busy, r_done;
    logic [CW-1:0] r_clk;
    logic [3:0]    r_bits;
    logic [8:0]    r_shift;

    assign o_tx   = r_tx;
    assign o_done = r_done;

    // Shift out start, 8 data bits LSB first, then stop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_clk   <= '0;
            r_bits  <= '0;
            r_shift <= '1;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_load) begin
                    r_shift <= {1'b1, i_data};
                    r_tx    <= 1'b0;
                    r_busy  <= 1'b1;
                    r_clk   <= '0;
                    r_bits  <= '0;
                end
            end else if (r_clk == FULL) begin
                r_clk <= '0;
                if (r_bits == 4'd9) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_tx   <= 1'b1;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                    r_bits  <= r_bits + 4'd1;
                end
            end else begin
                r_clk <= r_clk + 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart2wb.sv
// UART-side responder: receives a request frame, runs one Wishbone master
// cycle, returns one response frame. Half-duplex: bytes arriving while a
// cycle or response is in progress are dropped.
// Optional UART2WB_TIMEOUT_EN: abort a Wishbone cycle after 65535 cycles
// without ack and return zero data / a 0x00 write ack.
module uart2wb
    import uart_wb_pkg::*;
#(
    parameter int unsigned addr_width   = 8,
    parameter int unsigned data_width   = 8,
    parameter int unsigned strobe_width = data_width / 8,
    parameter int unsigned clk_per_bit  = 217
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      uart_rx,
    output logic      uart_tx,
    uart2wb_if.master wb
);
    localparam int unsigned NB  = data_width / 8;
    localparam logic [3:0]  NB4 = 4'(NB);

    state_t                  r_state, w_next;
    logic                    r_we, r_cyc, r_stb;
    logic [addr_width-1:0]   r_adr;
    logic [data_width-1:0]   r_datwr, r_resp;
    logic [strobe_width-1:0] r_sel;
    logic [3:0]              r_rx_cnt, r_tx_cnt, w_req_len, w_resp_len;
    logic [7:0]              w_rx_data;
    logic                    w_rx_valid, w_tx_done, w_tx_load;
    logic                    w_last_field, w_ack_hit, w_wb_end;

    uart_rx #(.clk_per_bit(clk_per_bit)) u_rx (
        .clock(clock), .reset(reset), .i_rx(uart_rx),
        .o_data(w_rx_data), .o_valid(w_rx_valid)
    );

    uart_tx #(.clk_per_bit(clk_per_bit)) u_tx (
        .clock(clock), .reset(reset), .i_data(r_resp[7:0]), .i_load(w_tx_load),
        .o_tx(uart_tx), .o_done(w_tx_done)
    );

    assign wb.wb_adr   = r_adr;
    assign wb.wb_datwr = r_datwr;
    assign wb.wb_we    = r_we;
    assign wb.wb_sel   = r_sel;
    assign wb.wb_stb   = r_stb;
    assign wb.wb_cyc   = r_cyc;

    assign w_req_len    = req_fields(r_we, NB);
    assign w_resp_len   = resp_bytes(r_we, NB);
    assign w_last_field = (r_state == RX_FIELDS) && w_rx_valid && (r_rx_cnt + 4'd1 == w_req_len);
    assign w_ack_hit    = r_stb && wb.wb_ack;
    // First byte loads on entry to TX_RESP; later bytes on the previous tx_done.
    assign w_tx_load    = (r_state == TX_RESP) &&
                          ((r_tx_cnt == 4'd0) || (w_tx_done && r_tx_cnt != w_resp_len));

`ifdef UART2WB_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        w_to_hit;

    // r_to_cnt holds (stb-high cycles - 1); 0xFFFE marks the 65535th cycle.
    assign w_to_hit = r_stb && !wb.wb_ack && (r_to_cnt == 16'hFFFE);
    assign w_wb_end = w_ack_hit || w_to_hit;

    // Count cycles spent waiting for ack while the strobe is up.
    always_ff @(posedge clock) begin
        if (reset || !r_stb) r_to_cnt <= '0;
        else                 r_to_cnt <= r_to_cnt + 16'd1;
    end
`else
    assign w_wb_end = w_ack_hit;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= RX_CMD;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_CMD:    if (w_rx_valid)   w_next = RX_FIELDS;
            RX_FIELDS: if (w_last_field) w_next = WB_REQ;
            WB_REQ:    if (w_wb_end)     w_next = TX_RESP;
            TX_RESP:   if (w_tx_done && r_tx_cnt == w_resp_len) w_next = RX_CMD;
            default:   w_next = RX_CMD;
        endcase
    end

    // Request capture, Wishbone drive and response sequencing.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_adr    <= '0;
            r_datwr  <= '0;
            r_sel    <= '0;
            r_resp   <= '0;
            r_rx_cnt <= '0;
            r_tx_cnt <= '0;
        end else begin
            case (r_state)
                RX_CMD: begin
                    if (w_rx_valid) begin
                        r_we     <= w_rx_data[WE_BIT];
                        r_rx_cnt <= '0;
                    end
                end
                RX_FIELDS: begin
                    if (w_rx_valid) begin
                        if (r_rx_cnt == 4'd0)
                            r_adr <= w_rx_data[addr_width-1:0];
                        else if (r_rx_cnt <= NB4)
                            r_datwr <= (r_datwr >> 8) | (data_width'(w_rx_data) << (data_width - 8));
                        else
                            r_sel <= w_rx_data[strobe_width-1:0];
                        if (r_rx_cnt != w_req_len) r_rx_cnt <= r_rx_cnt + 4'd1;
                        if (w_last_field) begin
                            r_cyc <= 1'b1;
                            r_stb <= 1'b1;
                        end
                    end
                end
                WB_REQ: begin
                    if (w_ack_hit) begin
                        r_resp   <= r_we ? data_width'(WR_ACK_OK) : wb.wb_datrd;
                        r_cyc    <= 1'b0;
                        r_stb    <= 1'b0;
                        r_tx_cnt <= '0;
                    end
`ifdef UART2WB_TIMEOUT_EN
                    else if (w_to_hit) begin
                        r_resp   <= r_we ? data_width'(WR_ACK_TIMEOUT) : '0;
                        r_cyc    <= 1'b0;
                        r_stb    <= 1'b0;
                        r_tx_cnt <= '0;
                    end
`endif
                end
                TX_RESP: begin
                    if (w_tx_load) begin
                        r_resp <= r_resp >> 8;
                        if (r_tx_cnt != w_resp_len) r_tx_cnt <= r_tx_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
